// File: rtl/decode_unit.sv
// decode_unit: RV32I instruction decode stage. Splits each instruction into the
// fields the datapath uses, and registers the result in a 2-entry skid buffer so
// that back-pressure never reaches fetch through a combinational path.
module decode_unit (
  input  logic        clock,
  input  logic        reset,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic [4:0]  opcode,
  output logic [2:0]  func3,
  output logic [6:0]  func7,
  output logic [31:0] imm,
  output logic        reg_write,
  output logic        illegal
);

  localparam logic [4:0] OP_LOAD   = 5'b00000;
  localparam logic [4:0] OP_IMM    = 5'b00100;
  localparam logic [4:0] OP_AUIPC  = 5'b00101;
  localparam logic [4:0] OP_STORE  = 5'b01000;
  localparam logic [4:0] OP_OP     = 5'b01100;
  localparam logic [4:0] OP_LUI    = 5'b01101;
  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_JALR   = 5'b11001;
  localparam logic [4:0] OP_JAL    = 5'b11011;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [4:0]  opcode;
    logic [2:0]  func3;
    logic [6:0]  func7;
    logic [31:0] imm;
    logic        reg_write;
    logic        illegal;
  } entry_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t state;
  entry_t main_q;
  entry_t skid_q;
  entry_t dec;
  logic   legal;
  logic   writes;
  logic   in_xfer;
  logic   out_xfer;

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;

  // Combinational decode of the incoming word into a full entry.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no latch can be inferred.
    dec           = '0;
    legal         = 1'b1;
    writes        = 1'b0;
    dec.pc        = in_pc;
    dec.rs1       = in_instr[19:15];
    dec.rs2       = in_instr[24:20];
    dec.rd        = in_instr[11:7];
    dec.opcode    = in_instr[6:2];
    dec.func3     = in_instr[14:12];
    dec.func7     = in_instr[31:25];
    case (in_instr[6:2])
      OP_LOAD, OP_IMM, OP_JALR: begin
        dec.imm = {{20{in_instr[31]}}, in_instr[31:20]};
        writes  = 1'b1;
      end
      OP_STORE:
        dec.imm = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      OP_BRANCH:
        dec.imm = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                   in_instr[30:25], in_instr[11:8], 1'b0};
      OP_LUI, OP_AUIPC: begin
        dec.imm = {in_instr[31:12], 12'b0};
        writes  = 1'b1;
      end
      OP_JAL: begin
        dec.imm = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                   in_instr[20], in_instr[30:21], 1'b0};
        writes  = 1'b1;
      end
      OP_OP:
        writes = 1'b1;
      default:
        legal = 1'b0;
    endcase
    if (in_instr[1:0] != 2'b11) legal = 1'b0;
    dec.illegal   = ~legal;
    dec.reg_write = legal & writes & (in_instr[11:7] != 5'd0);
    if (!legal) dec.imm = '0;
  end

  // Skid-buffer state machine with registered in_ready / out_valid.
  always_ff @(posedge clock) begin
    if (reset) begin
      // NOTE: both entries are cleared so every output field reads zero straight after reset.
      state     <= EMPTY;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      main_q    <= '0;
      skid_q    <= '0;
    end else if (flush) begin
      state     <= EMPTY;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every decision uses pre-edge values.
      case (state)
        EMPTY: begin
          if (in_xfer) begin
            main_q    <= dec;
            state     <= ONE;
            out_valid <= 1'b1;
          end
        end
        ONE: begin
          if (in_xfer && out_xfer) begin
            main_q <= dec;
          end else if (in_xfer) begin
            skid_q   <= dec;
            state    <= TWO;
            in_ready <= 1'b0;
          end else if (out_xfer) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
          end
        end
        TWO: begin
          if (out_xfer) begin
            main_q   <= skid_q;
            state    <= ONE;
            in_ready <= 1'b1;
          end
        end
        default: begin
          state     <= EMPTY;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign out_pc    = main_q.pc;
  assign rs1       = main_q.rs1;
  assign rs2       = main_q.rs2;
  assign rd        = main_q.rd;
  assign opcode    = main_q.opcode;
  assign func3     = main_q.func3;
  assign func7     = main_q.func7;
  assign imm       = main_q.imm;
  assign reg_write = main_q.reg_write;
  assign illegal   = main_q.illegal;

endmodule

// File: tb/tb_decode_unit.sv
// tb_decode_unit: directed decode vectors, skid-buffer corner cases and a
// scoreboarded random stream for decode_unit.
module tb_decode_unit;

  logic        clock = 1'b0;
  logic        reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_instr, in_pc, out_pc, imm;
  logic [4:0]  rs1, rs2, rd, opcode;
  logic [2:0]  func3;
  logic [6:0]  func7;
  logic        reg_write, illegal;

  always #5 clock = ~clock;

  decode_unit dut (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .rs1(rs1), .rs2(rs2), .rd(rd), .opcode(opcode), .func3(func3), .func7(func7),
    .imm(imm), .reg_write(reg_write), .illegal(illegal)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rs1, rs2, rd, opcode;
    logic [2:0]  func3;
    logic [6:0]  func7;
    logic [31:0] imm;
    logic        reg_write, illegal;
  } bundle_t;

  typedef struct {
    logic [31:0] instr;
    logic [4:0]  rs1, rs2, rd, opcode;
    logic [2:0]  func3;
    logic [6:0]  func7;
    logic [31:0] imm;
    logic        reg_write, illegal;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;
  bundle_t sb[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bundle_t observed();
    return {out_pc, rs1, rs2, rd, opcode, func3, func7, imm, reg_write, illegal};
  endfunction

  function automatic bundle_t from_vec(input vec_t v, input logic [31:0] pc);
    return {pc, v.rs1, v.rs2, v.rd, v.opcode, v.func3, v.func7, v.imm, v.reg_write, v.illegal};
  endfunction

  // Reference decoder: legality via an opcode bitmap, immediates via arithmetic shifts.
  function automatic bundle_t ref_decode(input logic [31:0] instr, input logic [31:0] pc);
    bundle_t     b;
    logic [31:0] mask;
    logic [31:0] t;
    logic        ok;
    mask = 32'h0B003131;
    b = '0;
    b.pc = pc; b.rs1 = instr[19:15]; b.rs2 = instr[24:20]; b.rd = instr[11:7];
    b.opcode = instr[6:2]; b.func3 = instr[14:12]; b.func7 = instr[31:25];
    ok = mask[instr[6:2]] && (instr[1:0] == 2'b11);
    b.illegal = !ok;
    if (ok) begin
      case (instr[6:2])
        5'b00000, 5'b00100, 5'b11001: begin t = instr; b.imm = $signed(t) >>> 20; end
        5'b01000: begin t = {instr[31:25], instr[11:7], 20'b0}; b.imm = $signed(t) >>> 20; end
        5'b11000: begin t = {instr[31], instr[7], instr[30:25], instr[11:8], 20'b0}; b.imm = $signed(t) >>> 19; end
        5'b11011: begin t = {instr[31], instr[19:12], instr[20], instr[30:21], 12'b0}; b.imm = $signed(t) >>> 11; end
        5'b00101, 5'b01101: b.imm = instr & 32'hFFFFF000;
        default: b.imm = 32'd0;
      endcase
      b.reg_write = (instr[6:2] != 5'b01000) && (instr[6:2] != 5'b11000) && (instr[11:7] != 5'd0);
    end
    return b;
  endfunction

  // One cycle of scoreboarded traffic; called at a negedge, returns at the next one.
  task automatic stream_step(input logic iv, input logic [31:0] instr, input logic [31:0] pc, input logic ordy);
    bundle_t e;
    in_valid = iv; in_instr = instr; in_pc = pc; out_ready = ordy;
    if (out_valid && out_ready) begin
      if (sb.size() == 0) check("stream_unexpected_out", {31'd0, out_valid}, 32'd0);
      else begin
        e = sb.pop_front();
        check("stream_entry", observed(), e);
      end
    end
    if (in_valid && in_ready) sb.push_back(ref_decode(instr, pc));
    @(negedge clock);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[11];
    logic [4:0] legal_ops[9];
    logic [31:0] w;

    vecs[0]  = '{32'h00500093, 5'd0,  5'd5,  5'd1,  5'b00100, 3'd0, 7'h00, 32'h00000005, 1'b1, 1'b0};
    vecs[1]  = '{32'h0020A423, 5'd1,  5'd2,  5'd8,  5'b01000, 3'd2, 7'h00, 32'h00000008, 1'b0, 1'b0};
    vecs[2]  = '{32'hFE000EE3, 5'd0,  5'd0,  5'd29, 5'b11000, 3'd0, 7'h7F, 32'hFFFFFFFC, 1'b0, 1'b0};
    vecs[3]  = '{32'h123452B7, 5'd8,  5'd3,  5'd5,  5'b01101, 3'd5, 7'h09, 32'h12345000, 1'b1, 1'b0};
    vecs[4]  = '{32'h00000013, 5'd0,  5'd0,  5'd0,  5'b00100, 3'd0, 7'h00, 32'h00000000, 1'b0, 1'b0};
    vecs[5]  = '{32'h00000000, 5'd0,  5'd0,  5'd0,  5'b00000, 3'd0, 7'h00, 32'h00000000, 1'b0, 1'b1};
    vecs[6]  = '{32'h008000EF, 5'd0,  5'd8,  5'd1,  5'b11011, 3'd0, 7'h00, 32'h00000008, 1'b1, 1'b0};
    vecs[7]  = '{32'hFFF12183, 5'd2,  5'd31, 5'd3,  5'b00000, 3'd2, 7'h7F, 32'hFFFFFFFF, 1'b1, 1'b0};
    vecs[8]  = '{32'hFFFFF017, 5'd31, 5'd31, 5'd0,  5'b00101, 3'd7, 7'h7F, 32'hFFFFF000, 1'b0, 1'b0};
    vecs[9]  = '{32'h000000FF, 5'd0,  5'd0,  5'd1,  5'b11111, 3'd0, 7'h00, 32'h00000000, 1'b0, 1'b1};
    vecs[10] = '{32'h00500091, 5'd0,  5'd5,  5'd1,  5'b00100, 3'd0, 7'h00, 32'h00000000, 1'b0, 1'b1};
    legal_ops = '{5'b00000, 5'b00100, 5'b00101, 5'b01000, 5'b01100,
                  5'b01101, 5'b11000, 5'b11001, 5'b11011};

    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; out_ready = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    check("reset_fields", observed(), '0);
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_in_ready", {31'd0, in_ready}, 32'd1);

    // Decode table, one instruction per cycle with out_ready held high.
    out_ready = 1'b1;
    for (int i = 0; i < 11; i++) begin
      in_valid = 1'b1; in_instr = vecs[i].instr; in_pc = 32'h100 + 32'(4 * i);
      @(negedge clock);
      check($sformatf("decode_%0d", i), {out_valid, observed()}, {1'b1, from_vec(vecs[i], 32'h100 + 32'(4 * i))});
      check($sformatf("decode_in_ready_%0d", i), {31'd0, in_ready}, 32'd1);
    end
    in_valid = 1'b0;
    @(negedge clock);
    check("decode_drained", {31'd0, out_valid}, 32'd0);

    // Back-pressure: 0x0 and 0x4 absorbed, 0x8 held, then drained with no gaps.
    out_ready = 1'b0; in_valid = 1'b1; in_instr = vecs[0].instr; in_pc = 32'h0;
    @(negedge clock);
    check("bp_first", {in_ready, out_valid, out_pc}, {1'b1, 1'b1, 32'h0});
    in_pc = 32'h4;
    @(negedge clock);
    check("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
    in_pc = 32'h8;
    @(negedge clock);
    check("bp_stable", {in_ready, out_valid, observed()}, {1'b0, 1'b1, from_vec(vecs[0], 32'h0)});
    out_ready = 1'b1;
    check("bp_out_0", {out_valid, out_pc}, {1'b1, 32'h0});
    @(negedge clock);
    check("bp_out_4", {in_ready, out_valid, out_pc}, {1'b1, 1'b1, 32'h4});
    @(negedge clock);
    in_valid = 1'b0;
    check("bp_out_8", {out_valid, out_pc}, {1'b1, 32'h8});
    @(negedge clock);
    check("bp_empty", {31'd0, out_valid}, 32'd0);

    // Flush while full: buffered and offered instructions never appear.
    out_ready = 1'b0; in_valid = 1'b1; in_pc = 32'h40;
    @(negedge clock);
    in_pc = 32'h44;
    @(negedge clock);
    check("flush_full_state", {in_ready, out_valid}, {1'b0, 1'b1});
    in_pc = 32'h48; flush = 1'b1;
    @(negedge clock);
    flush = 1'b0; in_valid = 1'b0;
    check("flush_full_after", {in_ready, out_valid}, {1'b1, 1'b0});
    out_ready = 1'b1; in_valid = 1'b1; in_pc = 32'h50;
    @(negedge clock);
    check("flush_next_entry", {out_valid, out_pc}, {1'b1, 32'h50});
    in_valid = 1'b0;
    @(negedge clock);
    check("flush_no_stale", {31'd0, out_valid}, 32'd0);

    // Flush in ONE with an acceptable input offered: that input is dropped.
    in_valid = 1'b1; in_pc = 32'h60;
    @(negedge clock);
    in_pc = 32'h64; flush = 1'b1;
    @(negedge clock);
    flush = 1'b0; in_valid = 1'b0;
    check("flush_one_after", {in_ready, out_valid}, {1'b1, 1'b0});
    @(negedge clock);
    check("flush_one_dropped", {31'd0, out_valid}, 32'd0);

    // Reset mid-stream, then a clean decode.
    out_ready = 1'b0; in_valid = 1'b1; in_instr = vecs[3].instr; in_pc = 32'h70;
    @(negedge clock);
    reset = 1'b1; in_pc = 32'h74;
    @(negedge clock);
    check("rst_mid_fields", {in_ready, out_valid, observed()}, {1'b1, 1'b0, 96'd0});
    reset = 1'b0; out_ready = 1'b1; in_instr = vecs[0].instr; in_pc = 32'h80;
    @(negedge clock);
    check("rst_post_decode", {out_valid, observed()}, {1'b1, from_vec(vecs[0], 32'h80)});
    in_valid = 1'b0;
    @(negedge clock);

    // Random stream with random back-pressure against the reference decoder.
    for (int i = 0; i < 400; i++) begin
      w = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        w[6:2] = legal_ops[$urandom_range(0, 8)];
        w[1:0] = 2'b11;
      end
      stream_step($urandom_range(0, 3) != 0, w, 32'h1000 + 32'(4 * i), $urandom_range(0, 2) != 0);
    end
    for (int i = 0; i < 10; i++) begin
      if (sb.size() != 0 || out_valid) stream_step(1'b0, 32'h0, 32'h0, 1'b1);
    end
    check("stream_drained", {32'(sb.size()), 31'd0, out_valid}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
